mem_access_seq: RTL

- Parametrised memory-access sequencer for the SLC-3 datapath.
- Replaces hand-unrolled wait-state chains in the ISDU (fetch, load and store waits) with one reusable block.
- Accepts one read or write request at a time from the control FSM and drives the synchronous BRAM enables for a configurable number of wait cycles.
- Returns a one-cycle completion pulse and a registered read word.

---
 rtl/mem_access_seq_pkg.sv | 22 ++
 rtl/mem_access_seq_if.sv | 37 +++
 rtl/mem_access_seq_wait_counter.sv | 39 +++
 rtl/mem_access_seq.sv | 115 +++++++++++
 4 files changed

// File: rtl/mem_access_seq_pkg.sv
// mem_seq_pkg: shared types and helpers for the memory-access sequencer.
//   seq_state_e - sequencer FSM states (idle, wait-state run, one-cycle response)
//   cnt_width() - width of the wait counter for a given pair of latencies
package mem_seq_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } seq_state_e;

  // Bits needed to hold max(rd_lat, wr_lat); never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned rd_lat,
                                            input int unsigned wr_lat);
    int unsigned max_lat;
    int unsigned w;
    max_lat = (rd_lat > wr_lat) ? rd_lat : wr_lat;
    w = $clog2(max_lat + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/mem_access_seq_if.sv
// mem_access_seq_if: request/response handshake plus BRAM bus of the sequencer.
//   req_*  - request from the control FSM (valid/ready handshake)
//   rsp_*  - completion pulse, kind of access and last read word
//   mem_*  - synchronous BRAM enables, address, write data and read data
//   busy   - sequencer not idle
// Modports: slave = sequencer side, master = control FSM / BRAM side.
interface mem_access_seq_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 16
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_we;
  logic [DATA_W-1:0] rsp_rdata;
  logic              mem_ena;
  logic              mem_wr_ena;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, mem_rdata,
    output req_ready, rsp_valid, rsp_we, rsp_rdata,
    output mem_ena, mem_wr_ena, mem_addr, mem_wdata, busy
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, mem_rdata,
    input  req_ready, rsp_valid, rsp_we, rsp_rdata,
    input  mem_ena, mem_wr_ena, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/mem_access_seq_wait_counter.sv
// wait_counter: loadable down-counter with zero flag (synchronous active-low reset).
//   clk_i, rst_ni - clock and synchronous reset (clears count to 0)
//   load_i        - load load_val_i (has priority over dec_i)
//   load_val_i    - value to load
//   dec_i         - decrement by one
//   cnt_o, zero_o - current count and count == 0
module wait_counter #(
  parameter int unsigned Width = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             dec_i,
  output logic [Width-1:0] cnt_o,
  output logic             zero_o
);
  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign zero_o = (cnt_q == '0);
endmodule

// File: rtl/mem_access_seq.sv
// mem_access_seq: one-at-a-time BRAM access sequencer for the SLC-3 ISDU.
//   clk, reset_n - rising-edge clock, synchronous active-low reset
//   bus_io       - slave side of mem_access_seq_if (request, response, BRAM bus)
// A handshake in cycle T holds mem_ena for LAT cycles (T+1..T+LAT), then pulses
// rsp_valid in T+LAT+1. Read data is captured on the last wait cycle.
module mem_access_seq
  import mem_seq_pkg::*;
#(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned RD_LATENCY = 3,
  parameter int unsigned WR_LATENCY = 1
) (
  input logic           clk,
  input logic           reset_n,
  mem_access_seq_if.slave bus_io
);
  localparam int unsigned CntW = cnt_width(RD_LATENCY, WR_LATENCY);
  localparam logic [CntW-1:0] RdLoad = CntW'(RD_LATENCY - 1);
  localparam logic [CntW-1:0] WrLoad = CntW'(WR_LATENCY - 1);

  if (RD_LATENCY < 1) begin : g_bad_rd_lat
    $error("mem_access_seq: RD_LATENCY must be >= 1");
  end
  if (WR_LATENCY < 1) begin : g_bad_wr_lat
    $error("mem_access_seq: WR_LATENCY must be >= 1");
  end

  seq_state_e        state_q, state_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              cnt_load, cnt_dec, cnt_zero;
  logic [CntW-1:0]   cnt_load_val;
  logic [CntW-1:0]   cnt_val;

  wait_counter #(
    .Width (CntW)
  ) u_wait_counter (
    .clk_i      (clk),
    .rst_ni     (reset_n),
    .load_i     (cnt_load),
    .load_val_i (cnt_load_val),
    .dec_i      (cnt_dec),
    .cnt_o      (cnt_val),
    .zero_o     (cnt_zero)
  );

  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    cnt_load     = 1'b0;
    cnt_dec      = 1'b0;
    cnt_load_val = bus_io.req_we ? WrLoad : RdLoad;
    unique case (state_q)
      StIdle: begin
        if (bus_io.req_valid) begin
          we_d     = bus_io.req_we;
          addr_d   = bus_io.req_addr;
          wdata_d  = bus_io.req_wdata;
          cnt_load = 1'b1;
          state_d  = StWait;
        end
      end
      StWait: begin
        if (cnt_zero) begin
          state_d = StResp;
          // BRAM output is valid on the last wait cycle; writes leave it alone.
          if (!we_q) begin
            rdata_d = bus_io.mem_rdata;
          end
        end else begin
          cnt_dec = 1'b1;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= StIdle;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // All outputs decode from registered state only: no req_* to mem_* path.
  assign bus_io.req_ready  = (state_q == StIdle);
  assign bus_io.busy       = (state_q != StIdle);
  assign bus_io.mem_ena    = (state_q == StWait);
  assign bus_io.mem_wr_ena = (state_q == StWait) && we_q;
  assign bus_io.mem_addr   = addr_q;
  assign bus_io.mem_wdata  = wdata_q;
  assign bus_io.rsp_valid  = (state_q == StResp);
  assign bus_io.rsp_we     = (state_q == StResp) && we_q;
  assign bus_io.rsp_rdata  = rdata_q;
endmodule
